// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
// Optional overflow flag enabled by defining BIN2BCD_ITER_OVF_EN.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A digit at or above this value would carry past 9 once doubled.
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    // Pre-shift correction so the doubled digit lands back in BCD range.
    localparam logic [3:0] ADJ_INC    = 4'd3;

endpackage

// File: rtl/bin2bcd_digit_adj.sv
// Single-digit double-dabble correction: add 3 when the digit is >= 5.
// Pure 4-bit arithmetic, so out-of-range input digits wrap.
module bin2bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Conditional add-3 ahead of the left shift.
    always_comb begin
        dout = din;
        if (din >= ADJ_THRESH) begin
            dout = din + ADJ_INC;
        end
    end

endmodule

// File: rtl/bin2bcd_iter.sv
// Iterative (one bit per cycle) binary-to-BCD converter, valid/ready I/O.
// Define BIN2BCD_ITER_OVF_EN to flag values that exceed NDIGITS digits.
module bin2bcd_iter
    import bin2bcd_pkg::*;
#(
    parameter int NBITS   = 8,
    parameter int NDIGITS = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [NBITS-1:0]       in_,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [4*NDIGITS-1:0]   out,
    output logic                   out_ovf
);

    localparam int CW = $clog2(NBITS + 1);
    localparam int BW = 4 * NDIGITS;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [NBITS-1:0] bin;
    logic [BW-1:0]   bcd;
    logic [BW-1:0]   adj;
    logic [BW:0]     shl;
    logic            accept;
    logic            last;

    assign accept = (state == IDLE) && in_val;
    assign last   = (cnt == CW'(NBITS - 1));

    for (genvar g = 0; g < NDIGITS; g++) begin : g_adj
        bin2bcd_digit_adj u_adj (
            .din  (bcd[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    // Corrected digits shifted left; binary MSB enters the ones digit.
    assign shl = {adj, bin[NBITS-1]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        out_val   = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_val = 1'b1;
                if (out_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shift datapath: load on accept, one double-dabble step per SHIFT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            bin <= '0;
            bcd <= '0;
        end else if (accept) begin
            cnt <= '0;
            bin <= in_;
            bcd <= '0;
        end else if (state == SHIFT) begin
            cnt <= cnt + CW'(1);
            bin <= bin << 1;
            bcd <= shl[BW-1:0];
        end
    end

    assign out = bcd;

`ifdef BIN2BCD_ITER_OVF_EN
    logic ovf;

    // Sticky flag: any 1 carried out of the top digit means truncation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= 1'b0;
        end else if (state == SHIFT) begin
            ovf <= ovf | shl[BW];
        end
    end

    assign out_ovf = ovf;
`else
    // The top carry is simply dropped; results wrap modulo 10^NDIGITS.
    logic unused_carry;
    assign unused_carry = shl[BW];
    assign out_ovf      = 1'b0;
`endif

endmodule
